// File: rtl/pb_debounce_pkg.sv
// Shared defaults and helpers for the pushbutton debouncer.
package pb_debounce_pkg;

    localparam int PB_DEFAULT_WIDTH         = 4;
    localparam int PB_DEFAULT_STABLE_CYCLES = 500000;

    // Counter width for a window of n cycles; never narrower than one bit.
    function automatic int pb_cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pb_debounce_bit.sv
// One debounce channel: two-flop synchronizer, stability counter, stable
// level register. With PB_DEBOUNCE_EVENT_EN defined it also registers
// one-cycle press/release strobes aligned with the stable level update.
module pb_debounce_bit
    import pb_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = PB_DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n_raw,
    output logic btn_n_db
`ifdef PB_DEBOUNCE_EVENT_EN
    ,
    output logic press_pulse,
    output logic release_pulse
`endif
);

    localparam int            CW       = pb_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1_d, sync1_q;
    logic          sync2_d, sync2_q;
    logic          stable_d, stable_q;
    logic [CW-1:0] cnt_d, cnt_q;
`ifdef PB_DEBOUNCE_EVENT_EN
    logic          press_d, press_q;
    logic          release_d, release_q;
`endif

    // Next state: a return to the old level throws away progress; the new
    // level is accepted only once it has held for the whole window.
    always_comb begin
        sync1_d  = btn_n_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
`ifdef PB_DEBOUNCE_EVENT_EN
        press_d   = stable_q & ~stable_d;
        release_d = ~stable_q & stable_d;
`endif
    end

    // State registers; reset means "button released" with no progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            stable_q  <= 1'b1;
            cnt_q     <= '0;
`ifdef PB_DEBOUNCE_EVENT_EN
            press_q   <= 1'b0;
            release_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
`ifdef PB_DEBOUNCE_EVENT_EN
            press_q   <= press_d;
            release_q <= release_d;
`endif
        end
    end

    assign btn_n_db = stable_q;
`ifdef PB_DEBOUNCE_EVENT_EN
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`endif

endmodule

// File: rtl/pushbutton_debouncer.sv
// Debounces WIDTH raw active-low pushbuttons into clean active-low levels
// for the pushbuttons PIO. Define PB_DEBOUNCE_EVENT_EN to add the
// press_pulse/release_pulse strobe outputs.
module pushbutton_debouncer
    import pb_debounce_pkg::*;
#(
    parameter int WIDTH         = PB_DEFAULT_WIDTH,
    parameter int STABLE_CYCLES = PB_DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_n_raw,
    output logic [WIDTH-1:0] btn_n_db
`ifdef PB_DEBOUNCE_EVENT_EN
    ,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
`endif
);

    // Channels are fully independent; one instance per button.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pb_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk           (clk),
            .reset_n       (reset_n),
            .btn_n_raw     (btn_n_raw[i]),
            .btn_n_db      (btn_n_db[i])
`ifdef PB_DEBOUNCE_EVENT_EN
            ,
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
`endif
        );
    end

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Directed bench for pushbutton_debouncer with WIDTH=4, STABLE_CYCLES=8.
// Edge 0 is the first rising edge after the raw input changes; the new
// level must be visible after edge 9 (10 edges total).
module tb_pushbutton_debouncer;

    localparam int W  = 4;
    localparam int SC = 8;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] btn_n_raw;
    logic [W-1:0] btn_n_db;
`ifdef PB_DEBOUNCE_EVENT_EN
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;
`endif

    int n_cmp;
    int n_bad;

    pushbutton_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_n_raw     (btn_n_raw),
        .btn_n_db      (btn_n_db)
`ifdef PB_DEBOUNCE_EVENT_EN
        ,
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then park on the falling edge to sample and drive.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Apply a level and wait long enough for every channel to settle.
    task automatic settle(input logic [W-1:0] v);
        btn_n_raw = v;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        btn_n_raw = 4'b0000;
        repeat (3) tick();
        n_cmp++;
        if (btn_n_db !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_hold: btn_n_db=%b expected=%b", btn_n_db, 4'b1111);
        end
        reset_n = 1'b1;
        repeat (9) tick();   // edges 0..8
        n_cmp++;
        if (btn_n_db !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_edge8: btn_n_db=%b expected=%b", btn_n_db, 4'b1111);
        end
        tick();              // edge 9
        n_cmp++;
        if (btn_n_db !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_edge9: btn_n_db=%b expected=%b", btn_n_db, 4'b0000);
        end
`ifdef PB_DEBOUNCE_EVENT_EN
        n_cmp++;
        if (press_pulse !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_press: press_pulse=%b expected=%b", press_pulse, 4'b1111);
        end
        tick();
        n_cmp++;
        if (press_pulse !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_press_width: press_pulse=%b expected=%b", press_pulse, 4'b0000);
        end
`endif
    endtask

    task automatic test_press();
        settle(4'b1111);
        btn_n_raw = 4'b1110;
        repeat (9) tick();
        n_cmp++;
        if (btn_n_db !== 4'b1111) begin
            n_bad++;
            $display("FAIL press_early: btn_n_db=%b expected=%b", btn_n_db, 4'b1111);
        end
        tick();
        n_cmp++;
        if (btn_n_db !== 4'b1110) begin
            n_bad++;
            $display("FAIL press_accept: btn_n_db=%b expected=%b", btn_n_db, 4'b1110);
        end
`ifdef PB_DEBOUNCE_EVENT_EN
        n_cmp++;
        if (press_pulse !== 4'b0001 || release_pulse !== 4'b0000) begin
            n_bad++;
            $display("FAIL press_strobe: press=%b release=%b expected press=0001 release=0000",
                     press_pulse, release_pulse);
        end
        tick();
        n_cmp++;
        if (press_pulse !== 4'b0000) begin
            n_bad++;
            $display("FAIL press_strobe_width: press_pulse=%b expected=%b", press_pulse, 4'b0000);
        end
`endif
        repeat (10) tick();
        n_cmp++;
        if (btn_n_db !== 4'b1110) begin
            n_bad++;
            $display("FAIL press_hold: btn_n_db=%b expected=%b", btn_n_db, 4'b1110);
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] seen;
        seen = '0;
        btn_n_raw = 4'b1100;
        repeat (5) tick();
        btn_n_raw = 4'b1110;
        tick();
        btn_n_raw = 4'b1100;     // final falling edge: next posedge is edge 0
        for (int k = 0; k < 9; k++) begin
            tick();
`ifdef PB_DEBOUNCE_EVENT_EN
            seen |= press_pulse;
`endif
        end
        n_cmp++;
        if (btn_n_db !== 4'b1110 || seen !== 4'b0000) begin
            n_bad++;
            $display("FAIL bounce_early: btn_n_db=%b strobes=%b expected db=1110 strobes=0000",
                     btn_n_db, seen);
        end
        tick();
        n_cmp++;
        if (btn_n_db !== 4'b1100) begin
            n_bad++;
            $display("FAIL bounce_accept: btn_n_db=%b expected=%b", btn_n_db, 4'b1100);
        end
`ifdef PB_DEBOUNCE_EVENT_EN
        n_cmp++;
        if (press_pulse !== 4'b0010) begin
            n_bad++;
            $display("FAIL bounce_strobe: press_pulse=%b expected=%b", press_pulse, 4'b0010);
        end
`endif
    endtask

    task automatic test_glitch();
        logic [W-1:0] seen;
        seen = '0;
        btn_n_raw = 4'b1000;
        repeat (7) tick();
        btn_n_raw = 4'b1100;
        for (int k = 0; k < 15; k++) begin
            tick();
`ifdef PB_DEBOUNCE_EVENT_EN
            seen |= press_pulse;
`endif
        end
        n_cmp++;
        if (btn_n_db !== 4'b1100 || seen !== 4'b0000) begin
            n_bad++;
            $display("FAIL glitch: btn_n_db=%b strobes=%b expected db=1100 strobes=0000",
                     btn_n_db, seen);
        end
    endtask

    task automatic test_simul_release();
        settle(4'b0110);
        n_cmp++;
        if (btn_n_db !== 4'b0110) begin
            n_bad++;
            $display("FAIL simul_setup: btn_n_db=%b expected=%b", btn_n_db, 4'b0110);
        end
        btn_n_raw = 4'b1111;
        repeat (9) tick();
        n_cmp++;
        if (btn_n_db !== 4'b0110) begin
            n_bad++;
            $display("FAIL simul_early: btn_n_db=%b expected=%b", btn_n_db, 4'b0110);
        end
        tick();
        n_cmp++;
        if (btn_n_db !== 4'b1111) begin
            n_bad++;
            $display("FAIL simul_accept: btn_n_db=%b expected=%b", btn_n_db, 4'b1111);
        end
`ifdef PB_DEBOUNCE_EVENT_EN
        n_cmp++;
        if (release_pulse !== 4'b1001 || press_pulse !== 4'b0000) begin
            n_bad++;
            $display("FAIL simul_strobe: release=%b press=%b expected release=1001 press=0000",
                     release_pulse, press_pulse);
        end
        tick();
        n_cmp++;
        if (release_pulse !== 4'b0000) begin
            n_bad++;
            $display("FAIL simul_strobe_width: release_pulse=%b expected=%b", release_pulse, 4'b0000);
        end
`endif
    endtask

    task automatic test_reset_mid_count();
        settle(4'b1111);
        btn_n_raw = 4'b1110;
        repeat (7) tick();       // edges 0..6: counter now at 5
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (btn_n_db !== 4'b1111) begin
            n_bad++;
            $display("FAIL midreset_hold: btn_n_db=%b expected=%b", btn_n_db, 4'b1111);
        end
        tick();
        tick();
        reset_n = 1'b1;          // next posedge is edge 0 of a fresh window
        repeat (9) tick();
        n_cmp++;
        if (btn_n_db !== 4'b1111) begin
            n_bad++;
            $display("FAIL midreset_early: btn_n_db=%b expected=%b", btn_n_db, 4'b1111);
        end
        tick();
        n_cmp++;
        if (btn_n_db !== 4'b1110) begin
            n_bad++;
            $display("FAIL midreset_accept: btn_n_db=%b expected=%b", btn_n_db, 4'b1110);
        end
    endtask

    task automatic test_async_reset();
        // Button accepted as pressed; reset between edges must release it at once.
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (btn_n_db !== 4'b1111) begin
            n_bad++;
            $display("FAIL async_reset: btn_n_db=%b expected=%b", btn_n_db, 4'b1111);
        end
        tick();
        reset_n = 1'b1;
        btn_n_raw = 4'b1111;
        repeat (3) tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        btn_n_raw = '1;
        reset_n   = 1'b1;
        #1;
        test_reset();
        test_press();
        test_bounce();
        test_glitch();
        test_simul_release();
        test_reset_mid_count();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pushbutton_debouncer.md
# pushbutton_debouncer

Synchronizes and debounces the raw active-low board pushbuttons before they reach the pushbuttons PIO's `in_port`. Each channel has a two-flop synchronizer and a stability counter. The debounced output keeps the pin polarity, so the PIO and software see clean, glitch-free levels. Optional one-cycle press/release event strobes are provided for hardware consumers.

## Interface
Parameters:
- `WIDTH`, 4: number of pushbutton channels.
- `STABLE_CYCLES`, 500000: consecutive synchronized cycles a new level must hold before it is accepted (10 ms at 50 MHz); legal range ≥ 2.

Ports (reset reset_n, asynchronous, active-low; clock clk):
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `btn_n_raw`  in  WIDTH  raw pushbutton pins, active-low, asynchronous to clk, bouncing.
- `btn_n_db`  out  WIDTH  debounced level, active-low; drives PIO `in_port`.
- `press_pulse`  out  WIDTH  one-cycle strobe on accepted 1→0 transition (only with macro).
- `release_pulse`  out  WIDTH  one-cycle strobe on accepted 0→1 transition (only with macro).

## Operation
- All channels are independent and identical.
- Synchronizer: `sync1 <= btn_n_raw[i]`, then `sync2 <= sync1`. Only `sync2` is used downstream.
- Per-channel state: `stable` (drives `btn_n_db[i]`) and counter `cnt`, width `$clog2(STABLE_CYCLES)`.
- Each clock, per channel:
  - `sync2 == stable`: `cnt <= 0` (bounce back to the old level discards progress).
  - `sync2 != stable` and `cnt != STABLE_CYCLES-1`: `cnt <= cnt+1`.
  - `sync2 != stable` and `cnt == STABLE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`.
- Event strobes are registered and asserted on the same edge `stable` updates:
  - `press_pulse[i]` on `stable` 1→0.
  - `release_pulse[i]` on `stable` 0→1.
  - Deasserted on every other cycle.
- The counter never exceeds STABLE_CYCLES-1 and never wraps.
- Reset values:
  - `sync1`, `sync2`, `stable` = all 1s (buttons released), so `btn_n_db` = {WIDTH{1'b1}}.
  - `cnt` = 0.
  - `press_pulse` and `release_pulse` = 0.
- Reset asserted mid-count discards the count. Outputs return to released immediately and asynchronously, even if a button is held. A button held through reset release is accepted as pressed after the full latency.
- Simultaneous changes on several channels are handled independently. Several strobe bits may be high in the same cycle.

## Timing
- Latency: with edge 0 being the first rising edge at which `sync1` captures the new level, `btn_n_db[i]` changes after edge STABLE_CYCLES+1. That is STABLE_CYCLES+2 edges in total, provided the level holds throughout.
- A glitch shorter than STABLE_CYCLES synchronized cycles never reaches `btn_n_db`.
- A single-cycle return to the old level at `sync2` restarts the full STABLE_CYCLES window.
- Strobes are exactly 1 cycle wide and coincide with the first cycle the new `btn_n_db` value is visible.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `PB_DEBOUNCE_EVENT_EN`.
- Defined: `press_pulse`/`release_pulse` ports and their registers exist, with the behaviour described above.
- Undefined: both ports are absent from the port list and no strobe logic is generated. `btn_n_db` behaviour is unchanged.

## Structure
- Package `pb_debounce_pkg`:
  - `PB_DEFAULT_WIDTH` = 4.
  - `PB_DEFAULT_STABLE_CYCLES` = 500000.
  - Function `pb_cnt_width(n)` returning `$clog2(n)` with a minimum of 1.
- Sub-module `pb_debounce_bit`: one channel (synchronizer, counter, stable register, optional strobes), instantiated WIDTH times in a generate loop by `pushbutton_debouncer`.

## Test plan
All scenarios use STABLE_CYCLES=8 and WIDTH=4.
- Reset with `btn_n_raw`=4'b0000 → `btn_n_db`=4'b1111 during reset; after release it becomes 4'b0000 after 10 edges, with `press_pulse`=4'b1111 for exactly that cycle.
- Clean press on bit 0 (4'b1111→4'b1110) held for 20 cycles → `btn_n_db[0]` falls after edge 9 (edge 0 being first capture). `press_pulse[0]` is high for 1 cycle. Other bits stay unchanged.
- Bounce on bit 1: low 5 cycles, high 1 cycle, then low steadily → no output change until 10 edges after the final falling edge. No early strobe.
- Glitch on bit 2: low for 7 cycles, then high → `btn_n_db[2]` stays 1 and `press_pulse[2]` never asserts.
- Bits 0 and 3 released simultaneously after being accepted pressed → both `btn_n_db` bits rise on the same edge, and `release_pulse`=4'b1001 for 1 cycle.
- `reset_n` asserted at cnt=5 while bit 0 is held low → `btn_n_db`=4'b1111 asynchronously. After deassertion a fresh 10-edge latency applies before bit 0 reads 0.
